wpack32: RTL and testbench

Word packer that assembles 32-bit values from two 16-bit bus writes. It presents each completed word on `dout` with a one-cycle `ld` strobe, and sits directly upstream of the 32-bit load-enabled sync register (`d` ← `dout`, `ld` ← `ld`). Halves may arrive in either order. A partial word can be discarded by an explicit abort or by a watchdog timeout.

---
 rtl/wpack_pkg.sv | 6 +
 rtl/wpack_wdog.sv | 21 ++
 rtl/wpack32.sv | 77 +++++++
 tb/tb_wpack32.sv | 135 +++++++++++++
 4 files changed

// File: rtl/wpack_pkg.sv
// wpack_pkg: shared state encoding and default watchdog parameters for wpack32
package wpack_pkg;
  typedef enum logic [1:0] {EMPTY = 2'd0, HAVE_LO = 2'd1, HAVE_HI = 2'd2} state_t;
  localparam int TIMEOUT_DEF = 15;
  localparam int TW_DEF = 4;
endpackage

// File: rtl/wpack_wdog.sv
// wpack_wdog: idle counter (clk, reset, run, clr -> expire) that fires on the cycle the count would reach TIMEOUT
module wpack_wdog
  import wpack_pkg::*;
#(
  parameter int TIMEOUT = TIMEOUT_DEF,
  parameter int TW = TW_DEF
) (
  input  logic clk,
  input  logic reset,
  input  logic run,
  input  logic clr,
  output logic expire
);
  localparam logic [TW-1:0] LAST = TW'(TIMEOUT > 0 ? TIMEOUT - 1 : 0);
  logic [TW-1:0] cnt;
  assign expire = (TIMEOUT > 0) && run && cnt == LAST;
  always_ff @(posedge clk or posedge reset)
    if (reset) cnt <= '0;
    else if (clr || expire) cnt <= '0;
    else if (run && TIMEOUT > 0) cnt <= cnt + TW'(1);
endmodule

// File: rtl/wpack32.sv
// wpack32: packs two 16-bit half writes (din, wr_lo, wr_hi, wr_abort, ovr_clr) into a 32-bit word (dout, ld, busy, ovr, tmo)
module wpack32
  import wpack_pkg::*;
#(
  parameter int TIMEOUT = TIMEOUT_DEF,
  parameter int TW = TW_DEF
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [15:0] din,
  input  logic        wr_lo,
  input  logic        wr_hi,
  input  logic        wr_abort,
  input  logic        ovr_clr,
  output logic [31:0] dout,
  output logic        ld,
  output logic        busy,
  output logic        ovr,
  output logic        tmo
);
  state_t state, state_n;
  logic [15:0] lo_r, hi_r, lo_n, hi_n;
  logic [31:0] word;
  logic done, set_ovr, expire, run, clr;
  assign run = state != EMPTY && !wr_lo && !wr_hi && !wr_abort;
  assign clr = wr_abort || wr_lo || wr_hi;
  wpack_wdog #(.TIMEOUT(TIMEOUT), .TW(TW)) u_wdog (
    .clk(clk), .reset(reset), .run(run), .clr(clr), .expire(expire)
  );
  always_comb begin
    state_n = state;
    lo_n = lo_r;
    hi_n = hi_r;
    word = dout;
    done = 1'b0;
    set_ovr = 1'b0;
    if (wr_abort) state_n = EMPTY;
    else if (wr_lo && wr_hi) begin
      done = 1'b1;
      word = {din, din};
      set_ovr = state != EMPTY;
      state_n = EMPTY;
    end else if (wr_lo) begin
      done = state == HAVE_HI;
      word = {hi_r, din};
      lo_n = din;
      set_ovr = state == HAVE_LO;
      state_n = state == HAVE_HI ? EMPTY : HAVE_LO;
    end else if (wr_hi) begin
      done = state == HAVE_LO;
      word = {din, lo_r};
      hi_n = din;
      set_ovr = state == HAVE_HI;
      state_n = state == HAVE_LO ? EMPTY : HAVE_HI;
    end else if (expire) state_n = EMPTY;
  end
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      state <= EMPTY;
      lo_r <= '0;
      hi_r <= '0;
      dout <= '0;
      ld <= 1'b0;
      busy <= 1'b0;
      ovr <= 1'b0;
      tmo <= 1'b0;
    end else begin
      state <= state_n;
      lo_r <= lo_n;
      hi_r <= hi_n;
      if (done) dout <= word;
      ld <= done;
      busy <= state_n != EMPTY;
      ovr <= set_ovr || (ovr && !ovr_clr);
      tmo <= expire;
    end
endmodule

// File: tb/tb_wpack32.sv
// tb_wpack32: table-driven and scoreboard checks of wpack32 with TIMEOUT=3
module tb_wpack32;
  logic clk = 1'b0, reset = 1'b1;
  logic [15:0] din = '0;
  logic wr_lo = 1'b0, wr_hi = 1'b0, wr_abort = 1'b0, ovr_clr = 1'b0;
  logic [31:0] dout;
  logic ld, busy, ovr, tmo;
  int checks = 0, failures = 0;
  typedef struct {
    logic lo, hi, ab, oc;
    logic [15:0] din;
    logic ld;
    logic [31:0] dout;
    logic busy, ovr, tmo;
  } vec_t;
  vec_t tbl[$];
  logic [31:0] sb[$];

  wpack32 #(.TIMEOUT(3), .TW(4)) dut (
    .clk(clk), .reset(reset), .din(din), .wr_lo(wr_lo), .wr_hi(wr_hi),
    .wr_abort(wr_abort), .ovr_clr(ovr_clr), .dout(dout), .ld(ld),
    .busy(busy), .ovr(ovr), .tmo(tmo)
  );

  always #5 clk = ~clk;

  function automatic vec_t mk(logic lo, logic hi, logic ab, logic oc, logic [15:0] d,
                              logic eld, logic [31:0] edout, logic eb, logic eo, logic et);
    vec_t v;
    v.lo = lo; v.hi = hi; v.ab = ab; v.oc = oc; v.din = d;
    v.ld = eld; v.dout = edout; v.busy = eb; v.ovr = eo; v.tmo = et;
    return v;
  endfunction

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic monitor(int idx);
    if (ld) begin
      checks++;
      if (sb.size() == 0) begin
        failures++;
        $display("FAIL sb_unexpected_ld row %0d: got dout %h expected no ld", idx, dout);
      end else begin
        logic [31:0] e;
        e = sb.pop_front();
        checks--;
        chk($sformatf("sb_word row %0d", idx), dout, e);
      end
    end
  endtask

  initial begin
    tbl.push_back(mk(1,0,0,0,16'h1234, 0,32'h00000000,1,0,0));
    tbl.push_back(mk(0,1,0,0,16'hABCD, 1,32'hABCD1234,0,0,0));
    tbl.push_back(mk(0,0,0,0,16'h0000, 0,32'hABCD1234,0,0,0));
    tbl.push_back(mk(0,1,0,0,16'h0F0F, 0,32'hABCD1234,1,0,0));
    tbl.push_back(mk(1,0,0,0,16'h5555, 1,32'h0F0F5555,0,0,0));
    tbl.push_back(mk(1,0,0,0,16'h5555, 0,32'h0F0F5555,1,0,0));
    tbl.push_back(mk(0,1,0,0,16'h0F0F, 1,32'h0F0F5555,0,0,0));
    tbl.push_back(mk(1,1,0,0,16'hBEEF, 1,32'hBEEFBEEF,0,0,0));
    tbl.push_back(mk(1,1,0,0,16'hBEEF, 1,32'hBEEFBEEF,0,0,0));
    tbl.push_back(mk(1,1,0,0,16'hBEEF, 1,32'hBEEFBEEF,0,0,0));
    tbl.push_back(mk(0,0,0,0,16'h0000, 0,32'hBEEFBEEF,0,0,0));
    tbl.push_back(mk(1,0,0,0,16'h1111, 0,32'hBEEFBEEF,1,0,0));
    tbl.push_back(mk(1,0,0,0,16'h2222, 0,32'hBEEFBEEF,1,1,0));
    tbl.push_back(mk(0,1,0,0,16'h3333, 1,32'h33332222,0,1,0));
    tbl.push_back(mk(0,0,0,1,16'h0000, 0,32'h33332222,0,0,0));
    tbl.push_back(mk(1,0,0,0,16'h4444, 0,32'h33332222,1,0,0));
    tbl.push_back(mk(0,0,0,0,16'h0000, 0,32'h33332222,1,0,0));
    tbl.push_back(mk(0,0,0,0,16'h0000, 0,32'h33332222,1,0,0));
    tbl.push_back(mk(0,0,0,0,16'h0000, 0,32'h33332222,0,0,1));
    tbl.push_back(mk(0,0,0,0,16'h0000, 0,32'h33332222,0,0,0));
    tbl.push_back(mk(0,1,0,0,16'h7777, 0,32'h33332222,1,0,0));
    tbl.push_back(mk(1,0,0,0,16'h8888, 1,32'h77778888,0,0,0));
    tbl.push_back(mk(1,0,0,0,16'h9999, 0,32'h77778888,1,0,0));
    tbl.push_back(mk(0,1,1,0,16'hAAAA, 0,32'h77778888,0,0,0));
    tbl.push_back(mk(0,1,0,0,16'h1357, 0,32'h77778888,1,0,0));
    tbl.push_back(mk(1,0,0,0,16'h2468, 1,32'h13572468,0,0,0));
    tbl.push_back(mk(1,0,0,0,16'h0001, 0,32'h13572468,1,0,0));
    tbl.push_back(mk(0,1,0,0,16'h0002, 1,32'h00020001,0,0,0));
    tbl.push_back(mk(1,0,0,0,16'h00AA, 0,32'h00020001,1,0,0));
    tbl.push_back(mk(1,0,0,1,16'h00BB, 0,32'h00020001,1,1,0));
    tbl.push_back(mk(0,1,0,0,16'h00CC, 1,32'h00CC00BB,0,1,0));
    tbl.push_back(mk(0,0,0,1,16'h0000, 0,32'h00CC00BB,0,0,0));
    tbl.push_back(mk(1,0,0,0,16'h5A5A, 0,32'h00CC00BB,1,0,0));

    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
    chk("reset_dout", dout, 32'h0);
    chk("reset_flags", {28'h0, ld, busy, ovr, tmo}, 32'h0);

    for (int i = 0; i < tbl.size(); i++) begin
      wr_lo = tbl[i].lo; wr_hi = tbl[i].hi; wr_abort = tbl[i].ab;
      ovr_clr = tbl[i].oc; din = tbl[i].din;
      if (tbl[i].ld) sb.push_back(tbl[i].dout);
      @(posedge clk);
      #1;
      monitor(i);
      chk($sformatf("row %0d ld", i), {31'h0, ld}, {31'h0, tbl[i].ld});
      chk($sformatf("row %0d dout", i), dout, tbl[i].dout);
      chk($sformatf("row %0d busy", i), {31'h0, busy}, {31'h0, tbl[i].busy});
      chk($sformatf("row %0d ovr", i), {31'h0, ovr}, {31'h0, tbl[i].ovr});
      chk($sformatf("row %0d tmo", i), {31'h0, tmo}, {31'h0, tbl[i].tmo});
    end
    wr_lo = 1'b0; wr_hi = 1'b0; wr_abort = 1'b0; ovr_clr = 1'b0;

    #2 reset = 1'b1;
    #1;
    chk("async_reset_dout", dout, 32'h0);
    chk("async_reset_flags", {28'h0, ld, busy, ovr, tmo}, 32'h0);
    @(posedge clk);
    #1 reset = 1'b0;
    wr_hi = 1'b1; din = 16'hC0DE;
    @(posedge clk);
    #1 wr_hi = 1'b0;
    monitor(-1);
    chk("post_reset_no_ld", {31'h0, ld}, 32'h0);
    chk("post_reset_busy", {31'h0, busy}, 32'h1);
    chk("post_reset_dout", dout, 32'h0);

    checks++;
    if (sb.size() != 0) begin
      failures++;
      $display("FAIL sb_leftover: got %0d pending words expected 0", sb.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
